// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> imem write port; holds CPU in reset until loaded.
// Option: IMEM_LOADER_CHECKSUM_EN appends a 4-byte mod-2^32 word-sum check before DONE.
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              clrn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_clrn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    WORD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [15:0]       MAX_N = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_IMG = CSUM;
  logic [31:0] sum_q;
`else
  localparam state_t AFTER_IMG = DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [1:0]  bcnt_q;
  logic [23:0] sr_q;
  logic        take, restart, word_end, last_word;
  logic [15:0] len_full;
  logic [31:0] word;

  assign rx_ready  = (state_q != DONE) && (state_q != ERR);
  assign take      = rx_valid & rx_ready;
  assign restart   = reload & ~rx_ready;
  assign word      = {sr_q, rx_data};
  assign len_full  = {len_q[7:0], rx_data};
  assign word_end  = take && (bcnt_q == 2'd3);
  assign last_word = (words_loaded + 16'd1) == len_q;
  assign busy      = rx_ready && (state_q != LEN_HI);
  assign done      = state_q == DONE;
  assign error     = state_q == ERR;
  // CPU reset follows clrn asynchronously, not just via the state register
  assign cpu_clrn  = clrn & done;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) state_q <= LEN_HI;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_HI: if (take) state_d = LEN_LO;
      LEN_LO: begin
        if (take) begin
          if (len_full > MAX_N)       state_d = ERR;
          else if (len_full == 16'd0) state_d = AFTER_IMG;
          else                        state_d = WORD;
        end
      end
      WORD: if (word_end && last_word) state_d = AFTER_IMG;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (word_end) state_d = (word == sum_q) ? DONE : ERR;
`endif
      DONE, ERR: if (reload) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      len_q        <= '0;
      bcnt_q       <= '0;
      sr_q         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE;
      imem_wdata   <= '0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        len_q        <= '0;
        bcnt_q       <= '0;
        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q        <= '0;
`endif
      end else if (take) begin
        if (state_q == LEN_HI) len_q <= {8'h00, rx_data};
        if (state_q == LEN_LO) len_q <= len_full;
        if (state_q != LEN_HI && state_q != LEN_LO) begin
          bcnt_q <= bcnt_q + 2'd1;
          sr_q   <= word[23:0];
        end
        if (state_q == WORD && word_end) begin
          imem_we      <= 1'b1;
          imem_addr    <= BASE + words_loaded[ADDR_W-1:0];
          imem_wdata   <= word;
          words_loaded <= words_loaded + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q        <= sum_q + word;
`endif
        end
      end
    end
  end

endmodule
